controle_banco_registro: RTL and testbench
==========================================

Name: controle_banco_registro

Overview:
- Controller on the datapath side of the register bank: it generates Habilita, IN_OUT_A, OUT_B and E, and consumes the A and B outputs.
- Sequences operand reads for decoded instructions and result writebacks from execute over the bank's shared A/write port.
- Keeps a 16-bit pending-write scoreboard that stalls RAW and WAW hazards.
- Sits between decode (req), execute (op), and the writeback source (wb).

Parameters:
- bits_palavra, 32, data word width
- end_registros, 4, register address width
- num_registros, 16, number of registers; equals scoreboard width

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  decode presents an instruction
- req_ready  out  1  controller accepts the instruction
- req_rs1  in  end_registros  source 1 address
- req_rs2  in  end_registros  source 2 address
- req_rd  in  end_registros  destination address
- req_wr  in  1  instruction will write req_rd
- op_valid  out  1  operands valid for execute
- op_ready  in  1  execute accepts the operands
- op_a  out  bits_palavra  value of rs1
- op_b  out  bits_palavra  value of rs2
- op_rd  out  end_registros  destination address passed through
- op_wr  out  1  destination write flag passed through
- wb_valid  in  1  writeback request
- wb_ready  out  1  writeback accepted
- wb_addr  in  end_registros  writeback address
- wb_data  in  bits_palavra  writeback data
- Habilita  out  1  bank write enable
- IN_OUT_A  out  end_registros  bank write/read-A address
- OUT_B  out  end_registros  bank read-B address
- E  out  bits_palavra  bank write data
- A  in  bits_palavra  bank output A
- B  in  bits_palavra  bank output B
- pend  out  num_registros  scoreboard; bit i set = write to register i outstanding

Behaviour:
- Bank timing: the bank acts on negedge clock. All bank-facing outputs are registered on posedge and held for the full cycle. A and B are sampled at the posedge that ends the read cycle.
- Reset (reset=0, takes effect immediately):
  - state=IDLE, ret=IDLE
  - op_a, op_b, op_rd, op_wr, Habilita, IN_OUT_A, OUT_B, E, pend all cleared to 0
  - op_valid, req_ready, wb_ready low while reset is held
  - any request in flight is discarded
- hazard = pend[req_rs1] | pend[req_rs2] | (req_wr & pend[req_rd]).
- wb_ready = (state==IDLE) | (state==OUT). Combinational.
- req_ready = (state==IDLE) & !wb_valid & !hazard. Combinational. Writeback always has priority over a new request.
- IDLE state:
  - wb_valid: latch wb_addr/wb_data into IN_OUT_A/E; clear pend[wb_addr]; ret=IDLE; go WB.
  - else req_valid & req_ready: IN_OUT_A=req_rs1, OUT_B=req_rs2; latch rd/wr; go RD.
- RD state (exactly 1 cycle, Habilita=0):
  - at exit posedge: op_a=A, op_b=B, op_rd/op_wr from latch
  - if wr, set pend[rd]
  - go OUT
- OUT state (op_valid=1; op_a/op_b/op_rd/op_wr held stable):
  - op_ready & !wb_valid: go IDLE.
  - wb_valid (with or without op_ready): accept the writeback as in IDLE; ret = op_ready ? IDLE : OUT; go WB.
- WB state (exactly 1 cycle):
  - Habilita=1, IN_OUT_A=wb address, E=wb data; bank writes at the mid-cycle negedge
  - op outputs unchanged
  - next state = ret
  - Habilita returns to 0 at the next posedge
- op_valid is high only in OUT, and in WB when ret=OUT.
- Writeback to an address whose pend bit is clear is legal and performs the write; the pend bit stays 0.
- pend set and clear can never target the same cycle: set occurs only on RD exit, clear only on wb accept in IDLE/OUT.
- Latencies:
  - req accept to op_valid = 2 clocks
  - wb accept to bank write = same cycle's following clock, at its negedge
- Bank output A during WB is ignored.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random inputs -> all outputs 0, pend=16'h0000, req_ready/wb_ready/op_valid low; release -> req_ready=1.
- Write then read: wb r3=32'hDEADBEEF in IDLE -> next cycle Habilita=1, IN_OUT_A=3, E=32'hDEADBEEF for 1 cycle. Then req rs1=3, rs2=0 -> op_valid 2 clocks after accept, op_a=32'hDEADBEEF, op_b=0.
- RAW stall: req rd=5 wr=1 accepted, op consumed -> pend[5]=1. Req rs1=5 held -> req_ready=0 until wb r5=32'h12 accepted. Then op_a=32'h12 and pend[5]=0.
- Backpressure with writeback: op_valid with op_ready=0, wb r7=32'hA5A5A5A5 -> WB cycle occurs, op_valid stays 1 with op_a/op_b unchanged, returns to OUT; op_ready=1 -> IDLE.
- Priority: req_valid and wb_valid both high in IDLE with no hazard -> req_ready=0, WB occurs first, request accepted the following cycle.
- Reset mid-operation: assert reset during RD and during WB -> all outputs clear immediately, pend=0, no further Habilita pulse after release.

Source files
------------

// File: rtl/controle_banco_registro.sv
`timescale 1ns/1ps
// Register-bank controller: reads two operands per decoded instruction,
// writes back execute results over the shared A/write port, and keeps a
// pending-write scoreboard that stalls RAW/WAW hazards at decode.
module controle_banco_registro #(
  parameter int bits_palavra  = 32,
  parameter int end_registros = 4,
  parameter int num_registros = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  // decode side
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [end_registros-1:0] req_rs1,
  input  logic [end_registros-1:0] req_rs2,
  input  logic [end_registros-1:0] req_rd,
  input  logic                     req_wr,
  // execute side
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [bits_palavra-1:0]  op_a,
  output logic [bits_palavra-1:0]  op_b,
  output logic [end_registros-1:0] op_rd,
  output logic                     op_wr,
  // writeback source
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [end_registros-1:0] wb_addr,
  input  logic [bits_palavra-1:0]  wb_data,
  // register bank
  output logic                     Habilita,
  output logic [end_registros-1:0] IN_OUT_A,
  output logic [end_registros-1:0] OUT_B,
  output logic [bits_palavra-1:0]  E,
  input  logic [bits_palavra-1:0]  A,
  input  logic [bits_palavra-1:0]  B,
  // scoreboard
  output logic [num_registros-1:0] pend
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  logic [1:0]               state;
  logic [1:0]               ret;
  logic [end_registros-1:0] rd_lat;
  logic                     wr_lat;
  logic                     hazard;
  logic                     wb_accept;
  logic                     req_accept;

  // Handshakes: writeback beats a new request, and the hazard check uses the
  // scoreboard as it stands. Reset holds every ready low.
  always_comb begin
    hazard     = pend[req_rs1] | pend[req_rs2] | (req_wr & pend[req_rd]);
    wb_ready   = reset & ((state == IDLE) | (state == OUT));
    req_ready  = reset & (state == IDLE) & ~wb_valid & ~hazard;
    op_valid   = (state == OUT) | ((state == WB) & (ret == OUT));
    wb_accept  = wb_valid & wb_ready;
    req_accept = req_valid & req_ready;
  end

  // Sequencer: IDLE -> RD -> OUT for reads, a one-cycle WB detour for writes
  // that returns to wherever it was entered from (ret).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ret    <= IDLE;
      rd_lat <= '0;
      wr_lat <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wb_accept) begin
            ret   <= IDLE;
            state <= WB;
          end else if (req_accept) begin
            rd_lat <= req_rd;
            wr_lat <= req_wr;
            state  <= RD;
          end
        end
        RD:  state <= OUT;
        OUT: begin
          if (wb_accept) begin
            // a simultaneous op_ready consumes the operands now
            ret   <= op_ready ? IDLE : OUT;
            state <= WB;
          end else if (op_ready) begin
            state <= IDLE;
          end
        end
        WB:      state <= ret;
        default: state <= IDLE;
      endcase
    end
  end

  // Bank port drive: registered on posedge so the bank sees stable values at
  // its negedge. Habilita is a single-cycle pulse covering the WB cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      Habilita <= 1'b0;
      IN_OUT_A <= '0;
      OUT_B    <= '0;
      E        <= '0;
    end else begin
      Habilita <= wb_accept;
      if (wb_accept) begin
        IN_OUT_A <= wb_addr;
        E        <= wb_data;
      end else if (req_accept) begin
        IN_OUT_A <= req_rs1;
        OUT_B    <= req_rs2;
      end
    end
  end

  // Operand capture at the end of the read cycle; held through OUT and WB.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_a  <= '0;
      op_b  <= '0;
      op_rd <= '0;
      op_wr <= 1'b0;
    end else if (state == RD) begin
      op_a  <= A;
      op_b  <= B;
      op_rd <= rd_lat;
      op_wr <= wr_lat;
    end
  end

  // Scoreboard: set when a writing instruction leaves RD, cleared when its
  // writeback is accepted. The two never happen in the same cycle since
  // writebacks are not accepted in RD.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend <= '0;
    end else begin
      if ((state == RD) && wr_lat) pend[rd_lat] <= 1'b1;
      if (wb_accept)               pend[wb_addr] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_controle_banco_registro.sv
`timescale 1ns/1ps
// Bench for controle_banco_registro: directed cycle table, reset corner
// sequences, and a randomized run against a transaction-level model.
module tb_controle_banco_registro;

  localparam int W  = 32;
  localparam int AW = 4;
  localparam int N  = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_wr;
  logic [AW-1:0] req_rs1, req_rs2, req_rd;
  logic          op_valid, op_ready, op_wr;
  logic [W-1:0]  op_a, op_b;
  logic [AW-1:0] op_rd;
  logic          wb_valid, wb_ready;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic          Habilita;
  logic [AW-1:0] IN_OUT_A, OUT_B;
  logic [W-1:0]  E, A, B;
  logic [N-1:0]  pend;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  controle_banco_registro #(.bits_palavra(W), .end_registros(AW), .num_registros(N)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_rd(req_rd), .req_wr(req_wr),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .op_rd(op_rd), .op_wr(op_wr),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .Habilita(Habilita), .IN_OUT_A(IN_OUT_A), .OUT_B(OUT_B), .E(E), .A(A), .B(B),
    .pend(pend)
  );

  // Register bank model: writes on negedge, reads combinationally.
  logic [W-1:0] bank [N] = '{default: '0};
  always @(negedge clock) if (Habilita) bank[IN_OUT_A] <= E;
  assign A = bank[IN_OUT_A];
  assign B = bank[OUT_B];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_rs1 = 0; req_rs2 = 0; req_rd = 0; req_wr = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0; op_ready = 0;
  endtask

  task automatic random_inputs();
    req_valid = 1'($urandom); req_rs1 = 4'($urandom); req_rs2 = 4'($urandom);
    req_rd = 4'($urandom); req_wr = 1'($urandom);
    wb_valid = 1'($urandom); wb_addr = 4'($urandom); wb_data = $urandom; op_ready = 1'($urandom);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ctl"}, 32'({Habilita, IN_OUT_A, OUT_B, op_rd, op_wr, op_valid, req_ready, wb_ready}), 32'd0);
    check({tag, "_E"}, E, 32'd0);
    check({tag, "_op_a"}, op_a, 32'd0);
    check({tag, "_op_b"}, op_b, 32'd0);
    check({tag, "_pend"}, 32'(pend), 32'd0);
  endtask

  // Issue one instruction and consume its operands; called just after a posedge.
  task automatic run_op(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd, input logic wr);
    logic acc, done;
    int   n;
    req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_wr = wr; req_valid = 1;
    n = 0;
    do begin
      @(negedge clock); acc = req_ready;
      @(posedge clock); #1; n++;
    end while (!acc && n < 20);
    req_valid = 0;
    check("run_op_accept", 32'(acc), 32'd1);
    op_ready = 1; n = 0;
    do begin
      @(negedge clock); done = op_valid;
      @(posedge clock); #1; n++;
    end while (!done && n < 20);
    op_ready = 0;
    check("run_op_operands", 32'(done), 32'd1);
  endtask

  typedef struct {
    logic        rv; logic [3:0] rs1, rs2, rd; logic wr;
    logic        wv; logic [3:0] wa; logic [31:0] wd;
    logic        ordy;
    logic        x_rr, x_wbr, x_ov, x_hab; logic [3:0] x_ioa;
    logic [31:0] x_e, x_a, x_b; logic [15:0] x_pend;
  } vec_t;

  typedef struct {
    logic [31:0] a, b; logic [3:0] rd; logic wr; int valid_at;
  } exp_op_t;

  vec_t          vecs [20];
  exp_op_t       exp_q [$];
  exp_op_t       e_op;
  logic [W-1:0]  model_regs [N];
  logic [N-1:0]  m_pend;
  logic          wb_now, nxt_wb, set_dly, head_valid, in_rd, hz, x_rr, x_wbr;
  logic [3:0]    wb_now_addr, set_dly_rd;
  logic [31:0]   wb_now_data;
  int            ops_done;

  initial begin
    //            rv rs1 rs2 rd wr  wv wa wd            ordy rr wbr ov hab ioa e            a             b  pend
    vecs[0]  = '{1, 3, 0, 1, 0,   1, 3, 32'hDEADBEEF, 0,   0, 1, 0, 0, 0, 0,            0,            0, 16'h0};
    vecs[1]  = '{1, 3, 0, 1, 0,   0, 0, 0,            0,   0, 0, 0, 1, 3, 32'hDEADBEEF, 0,            0, 16'h0};
    vecs[2]  = '{1, 3, 0, 1, 0,   0, 0, 0,            0,   1, 1, 0, 0, 0, 0,            0,            0, 16'h0};
    vecs[3]  = '{0, 0, 0, 0, 0,   0, 0, 0,            0,   0, 0, 0, 0, 0, 0,            0,            0, 16'h0};
    vecs[4]  = '{0, 0, 0, 0, 0,   0, 0, 0,            0,   0, 1, 1, 0, 0, 0,            32'hDEADBEEF, 0, 16'h0};
    vecs[5]  = '{0, 0, 0, 0, 0,   0, 0, 0,            1,   0, 1, 1, 0, 0, 0,            32'hDEADBEEF, 0, 16'h0};
    vecs[6]  = '{1, 0, 0, 5, 1,   0, 0, 0,            0,   1, 1, 0, 0, 0, 0,            0,            0, 16'h0};
    vecs[7]  = '{0, 0, 0, 0, 0,   0, 0, 0,            0,   0, 0, 0, 0, 0, 0,            0,            0, 16'h0};
    vecs[8]  = '{0, 0, 0, 0, 0,   0, 0, 0,            1,   0, 1, 1, 0, 0, 0,            0,            0, 16'h0020};
    vecs[9]  = '{1, 5, 0, 6, 0,   0, 0, 0,            0,   0, 1, 0, 0, 0, 0,            0,            0, 16'h0020};
    vecs[10] = '{1, 5, 0, 6, 0,   0, 0, 0,            0,   0, 1, 0, 0, 0, 0,            0,            0, 16'h0020};
    vecs[11] = '{1, 5, 0, 6, 0,   1, 5, 32'h12,       0,   0, 1, 0, 0, 0, 0,            0,            0, 16'h0020};
    vecs[12] = '{1, 5, 0, 6, 0,   0, 0, 0,            0,   0, 0, 0, 1, 5, 32'h12,       0,            0, 16'h0};
    vecs[13] = '{1, 5, 0, 6, 0,   0, 0, 0,            0,   1, 1, 0, 0, 0, 0,            0,            0, 16'h0};
    vecs[14] = '{0, 0, 0, 0, 0,   0, 0, 0,            0,   0, 0, 0, 0, 0, 0,            0,            0, 16'h0};
    vecs[15] = '{0, 0, 0, 0, 0,   0, 0, 0,            0,   0, 1, 1, 0, 0, 0,            32'h12,       0, 16'h0};
    vecs[16] = '{0, 0, 0, 0, 0,   1, 7, 32'hA5A5A5A5, 0,   0, 1, 1, 0, 0, 0,            32'h12,       0, 16'h0};
    vecs[17] = '{0, 0, 0, 0, 0,   0, 0, 0,            0,   0, 0, 1, 1, 7, 32'hA5A5A5A5, 32'h12,       0, 16'h0};
    vecs[18] = '{0, 0, 0, 0, 0,   0, 0, 0,            1,   0, 1, 1, 0, 0, 0,            32'h12,       0, 16'h0};
    vecs[19] = '{0, 0, 0, 0, 0,   0, 0, 0,            0,   1, 1, 0, 0, 0, 0,            0,            0, 16'h0};

    // Reset held with random inputs: everything stays cleared.
    idle_inputs();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1; random_inputs();
      @(negedge clock); check_cleared($sformatf("reset%0d", i));
    end
    @(posedge clock); #1; idle_inputs(); reset = 1;
    @(negedge clock);
    check("release_req_ready", 32'(req_ready), 32'd1);
    check("release_wb_ready", 32'(wb_ready), 32'd1);

    // Directed cycle table: write/read, priority, RAW stall, backpressure.
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      req_valid = vecs[i].rv; req_rs1 = vecs[i].rs1; req_rs2 = vecs[i].rs2;
      req_rd = vecs[i].rd; req_wr = vecs[i].wr;
      wb_valid = vecs[i].wv; wb_addr = vecs[i].wa; wb_data = vecs[i].wd; op_ready = vecs[i].ordy;
      @(negedge clock);
      check($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].x_rr));
      check($sformatf("vec%0d_wb_ready", i), 32'(wb_ready), 32'(vecs[i].x_wbr));
      check($sformatf("vec%0d_op_valid", i), 32'(op_valid), 32'(vecs[i].x_ov));
      check($sformatf("vec%0d_habilita", i), 32'(Habilita), 32'(vecs[i].x_hab));
      check($sformatf("vec%0d_pend", i), 32'(pend), 32'(vecs[i].x_pend));
      if (vecs[i].x_hab) begin
        check($sformatf("vec%0d_in_out_a", i), 32'(IN_OUT_A), 32'(vecs[i].x_ioa));
        check($sformatf("vec%0d_e", i), E, vecs[i].x_e);
      end
      if (vecs[i].x_ov) begin
        check($sformatf("vec%0d_op_a", i), op_a, vecs[i].x_a);
        check($sformatf("vec%0d_op_b", i), op_b, vecs[i].x_b);
      end
    end

    // Reset during the read cycle: the writing instruction is discarded.
    @(posedge clock); #1;
    req_valid = 1; req_rs1 = 3; req_rs2 = 7; req_rd = 2; req_wr = 1;
    @(negedge clock); check("rstrd_accept", 32'(req_ready), 32'd1);
    @(posedge clock); #1; req_valid = 0;
    #2 reset = 0;
    #1 check_cleared("rstrd_now");
    @(posedge clock); #1; reset = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("rstrd_after%0d", i), 32'({Habilita, op_valid, pend}), 32'd0);
      @(posedge clock); #1;
    end

    // Reset during a WB cycle: write suppressed, remaining pend bit cleared.
    run_op(0, 0, 9, 1);
    run_op(0, 0, 10, 1);
    @(negedge clock); check("rstwb_pend_before", 32'(pend), 32'h0600);
    @(posedge clock); #1; wb_valid = 1; wb_addr = 9; wb_data = 32'h55;
    @(negedge clock); check("rstwb_wb_ready", 32'(wb_ready), 32'd1);
    @(posedge clock); #1; wb_valid = 0;
    #1 check("rstwb_habilita", 32'(Habilita), 32'd1);
    check("rstwb_pend_mid", 32'(pend), 32'h0400);
    #1 reset = 0;
    #1 check_cleared("rstwb_now");
    @(posedge clock); #1; reset = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("rstwb_after%0d", i), 32'({Habilita, op_valid, pend}), 32'd0);
      @(posedge clock); #1;
    end
    check("rstwb_no_write", bank[9], 32'd0);

    // Randomized run against a transaction-level model.
    for (int i = 0; i < N; i++) model_regs[i] = bank[i];
    m_pend = '0; wb_now = 0; set_dly = 0; set_dly_rd = 0; wb_now_addr = 0; wb_now_data = 0;
    ops_done = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock); #1;
      req_valid = ($urandom_range(3) != 0);
      req_rs1 = 4'($urandom_range(7)); req_rs2 = 4'($urandom_range(7));
      req_rd = 4'($urandom_range(7)); req_wr = 1'($urandom);
      wb_valid = ($urandom_range(3) == 0);
      wb_addr = 4'($urandom);
      if (m_pend != 0 && $urandom_range(1) == 1) begin
        int start = $urandom_range(15);
        for (int k = 0; k < N; k++)
          if (m_pend[(start + k) % N]) wb_addr = 4'((start + k) % N);
      end
      wb_data = $urandom;
      op_ready = 1'($urandom);
      @(negedge clock);
      head_valid = (exp_q.size() > 0) && (c >= exp_q[0].valid_at);
      in_rd = (exp_q.size() > 0) && (c < exp_q[0].valid_at);
      hz = m_pend[req_rs1] | m_pend[req_rs2] | (req_wr & m_pend[req_rd]);
      x_rr = (exp_q.size() == 0) && !wb_now && !wb_valid && !hz;
      x_wbr = !wb_now && !in_rd;
      check("rnd_req_ready", 32'(req_ready), 32'(x_rr));
      check("rnd_wb_ready", 32'(wb_ready), 32'(x_wbr));
      check("rnd_op_valid", 32'(op_valid), 32'(head_valid));
      check("rnd_habilita", 32'(Habilita), 32'(wb_now));
      check("rnd_pend", 32'(pend), 32'(m_pend));
      if (wb_now) begin
        check("rnd_in_out_a", 32'(IN_OUT_A), 32'(wb_now_addr));
        check("rnd_e", E, wb_now_data);
      end
      if (head_valid) begin
        check("rnd_op_a", op_a, exp_q[0].a);
        check("rnd_op_b", op_b, exp_q[0].b);
        check("rnd_op_rd_wr", 32'({op_rd, op_wr}), 32'({exp_q[0].rd, exp_q[0].wr}));
      end
      // advance the model to the state after the coming posedge
      if (set_dly) m_pend[set_dly_rd] = 1'b1;
      set_dly = 0;
      nxt_wb = wb_valid && x_wbr;
      if (nxt_wb) begin
        model_regs[wb_addr] = wb_data;
        m_pend[wb_addr] = 1'b0;
      end
      if (head_valid && op_ready && !wb_now) begin
        void'(exp_q.pop_front());
        ops_done++;
      end
      if (req_valid && x_rr) begin
        e_op.a = model_regs[req_rs1]; e_op.b = model_regs[req_rs2];
        e_op.rd = req_rd; e_op.wr = req_wr; e_op.valid_at = c + 2;
        exp_q.push_back(e_op);
        if (req_wr) begin set_dly = 1; set_dly_rd = req_rd; end
      end
      wb_now = nxt_wb; wb_now_addr = wb_addr; wb_now_data = wb_data;
    end
    check("rnd_progress", 32'(ops_done >= 50), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
